// File: rtl/fpu_multiply_iterative_if.sv
// Operand/result handshake bundle for the iterative float multiplier.
interface fpu_multiply_iterative_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exponent;
  logic [23:0] out_mantissa;
  logic [2:0]  out_guard;
  logic        out_nan;
  logic        out_inf;
  logic        out_zero;
  logic [2:0]  out_mode;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_sign, out_exponent, out_mantissa,
           out_guard, out_nan, out_inf, out_zero, out_mode
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_sign, out_exponent, out_mantissa,
           out_guard, out_nan, out_inf, out_zero, out_mode
  );
endinterface

// File: rtl/fpu_multiply_iterative.sv
// Sequential binary32 multiplier: radix-2^BITS_PER_CYCLE shift-add, emits the
// unrounded unpacked result (sign, biased exp, 24b mantissa, GRS, flags, mode).
module fpu_multiply_iterative #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  fpu_multiply_iterative_if.slave  bus
);
  localparam int B    = BITS_PER_CYCLE;
  localparam int ITER = 24 / B;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, BUSY, NORM, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [47:0]   acc;
  logic [47:0]   ma_sh;
  logic [23:0]   mb_sh;
  logic [7:0]    ea, eb;
  logic          sign_q;
  logic [2:0]    mode_q;
  logic          a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

  logic          rdy, vld;
  logic          sign_o, nan_o, inf_o, zero_o;
  logic [7:0]    exp_o;
  logic [23:0]   mant_o;
  logic [2:0]    guard_o, mode_o;

  logic [47:0]       partial;
  logic signed [9:0] e_fin;
  logic              nan_f, inf_f, zero_f;
  logic [7:0]        a_exp, b_exp;
  logic              a_mnz, b_mnz;

  assign a_exp = bus.in_a[30:23];
  assign b_exp = bus.in_b[30:23];
  assign a_mnz = |bus.in_a[22:0];
  assign b_mnz = |bus.in_b[22:0];

  always_comb begin
    // ma_sh is already shifted to the weight of the current digit of mb
    partial = ma_sh * {{(48-B){1'b0}}, mb_sh[B-1:0]};
    e_fin   = $signed({2'b00, ea} + {2'b00, eb} - 10'd127 + {9'd0, acc[47]});
    nan_f   = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    inf_f   = !nan_f && (a_inf || b_inf || e_fin >= 10'sd255);
    zero_f  = !nan_f && !inf_f && (a_zero || b_zero || e_fin <= 10'sd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rdy     <= 1'b1;
      vld     <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      ma_sh   <= '0;
      mb_sh   <= '0;
      ea      <= '0;
      eb      <= '0;
      sign_q  <= 1'b0;
      mode_q  <= '0;
      a_nan   <= 1'b0;
      a_inf   <= 1'b0;
      a_zero  <= 1'b0;
      b_nan   <= 1'b0;
      b_inf   <= 1'b0;
      b_zero  <= 1'b0;
      sign_o  <= 1'b0;
      exp_o   <= '0;
      mant_o  <= '0;
      guard_o <= '0;
      nan_o   <= 1'b0;
      inf_o   <= 1'b0;
      zero_o  <= 1'b0;
      mode_o  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ma_sh  <= {24'd0, 1'b1, bus.in_a[22:0]};
          mb_sh  <= {1'b1, bus.in_b[22:0]};
          ea     <= a_exp;
          eb     <= b_exp;
          sign_q <= bus.in_a[31] ^ bus.in_b[31];
          mode_q <= bus.in_mode;
          a_nan  <= (a_exp == 8'hFF) && a_mnz;
          a_inf  <= (a_exp == 8'hFF) && !a_mnz;
          a_zero <= (a_exp == 8'h00);
          b_nan  <= (b_exp == 8'hFF) && b_mnz;
          b_inf  <= (b_exp == 8'hFF) && !b_mnz;
          b_zero <= (b_exp == 8'h00);
          acc    <= '0;
          cnt    <= '0;
          rdy    <= 1'b0;
          state  <= BUSY;
        end
        BUSY: begin
          acc   <= acc + partial;
          ma_sh <= ma_sh << B;
          mb_sh <= mb_sh >> B;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= NORM;
        end
        NORM: begin
          sign_o <= sign_q;
          mode_o <= mode_q;
          nan_o  <= nan_f;
          inf_o  <= inf_f;
          zero_o <= zero_f;
          if (nan_f || inf_f) begin
            exp_o   <= 8'hFF;
            mant_o  <= '0;
            guard_o <= '0;
          end else if (zero_f) begin
            exp_o   <= 8'h00;
            mant_o  <= '0;
            guard_o <= '0;
          end else begin
            exp_o <= e_fin[7:0];
            if (acc[47]) begin
              mant_o  <= acc[47:24];
              guard_o <= {acc[23], acc[22], |acc[21:0]};
            end else begin
              mant_o  <= acc[46:23];
              guard_o <= {acc[22], acc[21], |acc[20:0]};
            end
          end
          vld   <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          vld   <= 1'b0;
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = rdy;
  assign bus.out_valid    = vld;
  assign bus.out_sign     = sign_o;
  assign bus.out_exponent = exp_o;
  assign bus.out_mantissa = mant_o;
  assign bus.out_guard    = guard_o;
  assign bus.out_nan      = nan_o;
  assign bus.out_inf      = inf_o;
  assign bus.out_zero     = zero_o;
  assign bus.out_mode     = mode_o;
endmodule

// File: tb/tb_fpu_multiply_iterative.sv
// Directed bench: the same operand stream drives a BITS_PER_CYCLE=1 and a =4
// instance side by side; each result and latency is checked against hand values.
module tb_fpu_multiply_iterative;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_mode;

  fpu_multiply_iterative_if bus1 ();
  fpu_multiply_iterative_if bus4 ();

  assign bus1.in_valid  = in_valid;
  assign bus1.in_a      = in_a;
  assign bus1.in_b      = in_b;
  assign bus1.in_mode   = in_mode;
  assign bus1.out_ready = out_ready;
  assign bus4.in_valid  = in_valid;
  assign bus4.in_a      = in_a;
  assign bus4.in_b      = in_b;
  assign bus4.in_mode   = in_mode;
  assign bus4.out_ready = out_ready;

  fpu_multiply_iterative #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fpu_multiply_iterative #(.BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  logic [1:0]  ov, ir;
  logic [41:0] res [2];
  assign ov = {bus4.out_valid, bus1.out_valid};
  assign ir = {bus4.in_ready, bus1.in_ready};
  assign res[0] = {bus1.out_sign, bus1.out_exponent, bus1.out_mantissa, bus1.out_guard,
                   bus1.out_nan, bus1.out_inf, bus1.out_zero, bus1.out_mode};
  assign res[1] = {bus4.out_sign, bus4.out_exponent, bus4.out_mantissa, bus4.out_guard,
                   bus4.out_nan, bus4.out_inf, bus4.out_zero, bus4.out_mode};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
    end
  endtask

  // flags are {nan, inf, zero}
  function automatic logic [41:0] r(input logic s, input logic [7:0] e, input logic [23:0] m,
                                    input logic [2:0] g, input logic [2:0] f, input logic [2:0] md);
    return {s, e, m, g, f, md};
  endfunction

  function automatic int lat_exp(input int k);
    return (k == 0) ? 26 : 8;
  endfunction

  // Called at a negedge with both instances idle; leaves both idle at a negedge.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] md, input logic [41:0] exp_r, input int hold);
    int lat [2];
    int n;
    chk({name, ".in_ready"}, 64'(ir), 64'd3);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_mode = md;
    lat[0] = 0;
    lat[1] = 0;
    n = 0;
    while (ov != 2'b11 && n < 100) begin
      @(negedge clk);
      n++;
      in_valid = 1'b0;
      in_a = 32'hDEADBEEF;
      in_b = 32'hDEADBEEF;
      in_mode = ~md;
      for (int k = 0; k < 2; k++) if (ov[k] && lat[k] == 0) lat[k] = n;
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.lat%0d", name, k), 64'(lat[k]), 64'(lat_exp(k)));
      chk($sformatf("%s.res%0d", name, k), 64'(res[k]), 64'(exp_r));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("%s.hold%0d.ov", name, i), 64'(ov), 64'd3);
      chk($sformatf("%s.hold%0d.ir", name, i), 64'(ir), 64'd0);
      for (int k = 0; k < 2; k++)
        chk($sformatf("%s.hold%0d.res%0d", name, i, k), 64'(res[k]), 64'(exp_r));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, ".ov_drop"}, 64'(ov), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    in_mode = '0;
    repeat (2) @(negedge clk);
    chk("reset.ov", 64'(ov), 64'd0);
    chk("reset.ir", 64'(ir), 64'd3);
    chk("reset.res0", 64'(res[0]), 64'd0);
    chk("reset.res1", 64'(res[1]), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("1.5x2",    32'h3FC00000, 32'h40000000, 3'd0, r(0, 8'd128, 24'hC00000, 3'b000, 3'b000, 3'd0), 0);
    run_op("-2x3",     32'hC0000000, 32'h40400000, 3'd1, r(1, 8'd129, 24'hC00000, 3'b000, 3'b000, 3'd1), 0);
    run_op("ulp_sq",   32'h3F800001, 32'h3F800001, 3'd2, r(0, 8'd127, 24'h800002, 3'b001, 3'b000, 3'd2), 0);
    run_op("1.5x1.5",  32'h3FC00000, 32'h3FC00000, 3'd3, r(0, 8'd128, 24'h900000, 3'b000, 3'b000, 3'd3), 0);
    run_op("max_mant", 32'h3FFFFFFF, 32'h3FFFFFFF, 3'd4, r(0, 8'd128, 24'hFFFFFE, 3'b001, 3'b000, 3'd4), 0);
    run_op("ovf",      32'h7F000000, 32'h7F000000, 3'd0, r(0, 8'd255, 24'h0, 3'b000, 3'b010, 3'd0), 0);
    run_op("ovf_carry",32'h7F400000, 32'h3FC00000, 3'd0, r(0, 8'd255, 24'h0, 3'b000, 3'b010, 3'd0), 0);
    run_op("e254",     32'h7F000000, 32'h3F800000, 3'd1, r(0, 8'd254, 24'h800000, 3'b000, 3'b000, 3'd1), 0);
    run_op("inf_x_0",  32'h7F800000, 32'h00000000, 3'd0, r(0, 8'd255, 24'h0, 3'b000, 3'b100, 3'd0), 0);
    run_op("nan_op",   32'hFFC00000, 32'h3F800000, 3'd5, r(1, 8'd255, 24'h0, 3'b000, 3'b100, 3'd5), 0);
    run_op("-inf_x2",  32'hFF800000, 32'h40000000, 3'd0, r(1, 8'd255, 24'h0, 3'b000, 3'b010, 3'd0), 0);
    run_op("denorm",   32'h00000001, 32'h3F800000, 3'd0, r(0, 8'd0, 24'h0, 3'b000, 3'b001, 3'd0), 0);
    run_op("uflow",    32'h00800000, 32'h00800000, 3'd0, r(0, 8'd0, 24'h0, 3'b000, 3'b001, 3'd0), 0);
    run_op("e0",       32'h3F000000, 32'h00800000, 3'd0, r(0, 8'd0, 24'h0, 3'b000, 3'b001, 3'd0), 0);
    run_op("e1",       32'h3F000000, 32'h01000000, 3'd6, r(0, 8'd1, 24'h800000, 3'b000, 3'b000, 3'd6), 0);
    run_op("stall",    32'h3FC00000, 32'h40000000, 3'd7, r(0, 8'd128, 24'hC00000, 3'b000, 3'b000, 3'd7), 10);
    // back-to-back: run_op starts on the cycle right after the handshake
    run_op("after_stall", 32'hC0000000, 32'h40400000, 3'd2, r(1, 8'd129, 24'hC00000, 3'b000, 3'b000, 3'd2), 0);

    // abort in BUSY cycle 5
    chk("abort.ir0", 64'(ir), 64'd3);
    in_valid = 1'b1;
    in_a = 32'h3FC00000;
    in_b = 32'h40000000;
    in_mode = 3'd0;
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("abort.busy_ir", 64'(ir), 64'd0);
    rst = 1'b1;
    #1;
    chk("abort.ov", 64'(ov), 64'd0);
    chk("abort.ir", 64'(ir), 64'd3);
    chk("abort.res0", 64'(res[0]), 64'd0);
    chk("abort.res1", 64'(res[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 32'h3FC00000, 32'h40000000, 3'd0, r(0, 8'd128, 24'hC00000, 3'b000, 3'b000, 3'd0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
